// File: rtl/lcd_write_sequencer.sv
// Purpose: pops FWFT display-FIFO words and turns them into LCD write strobes (cmd/data/pixel-run/delay).
// Latency: pop -> SETUP next clock; each write takes 1+WR_LOW_CYCLES+WR_HIGH_CYCLES clocks plus one IDLE fetch clock per word.
// Backpressure: pops only from IDLE with i_enable high and FIFO non-empty; an accepted word always runs to completion.
module lcd_write_sequencer #(
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2
) (
    input  logic        i_clock,
    input  logic        i_nReset,
    input  logic        i_enable,
    input  logic [31:0] i_fifoData,
    input  logic        i_fifoEmpty,
    output logic        o_fifoRead,
    output logic [15:0] o_lcdData,
    output logic        o_lcdDc,
    output logic        o_lcdWr_n,
    output logic        o_lcdCs_n,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WR_LOW,
        WR_HIGH,
        DELAY
    } state_t;

    localparam logic [23:0] LOW_LOAD  = 24'(WR_LOW_CYCLES - 1);
    localparam logic [23:0] HIGH_LOAD = 24'(WR_HIGH_CYCLES - 1);

    state_t      state, stateNext;
    logic [23:0] timer, timerNext;
    logic [13:0] runCnt, runCntNext;
    logic [15:0] dataNext;
    logic        dcNext;
    logic [1:0]  wordType;

    assign wordType   = i_fifoData[31:30];
    // Gated by reset so no pop can slip through while the block is held in reset.
    assign o_fifoRead = i_nReset && (state == IDLE) && i_enable && !i_fifoEmpty;
    assign o_busy     = (state != IDLE);

    always_comb begin
        stateNext  = state;
        timerNext  = timer;
        runCntNext = runCnt;
        dataNext   = o_lcdData;
        dcNext     = o_lcdDc;
        case (state)
            IDLE: begin
                if (o_fifoRead) begin
                    if (wordType == 2'b11) begin
                        if (i_fifoData[23:0] != 24'd0) begin
                            timerNext = i_fifoData[23:0] - 24'd1;
                            stateNext = DELAY;
                        end
                    end else begin
                        stateNext  = SETUP;
                        runCntNext = (wordType == 2'b00) ? i_fifoData[29:16] : 14'd0;
                        dataNext   = (wordType == 2'b00) ? i_fifoData[15:0]
                                                         : {8'h00, i_fifoData[7:0]};
                        dcNext     = (wordType != 2'b01);
                    end
                end
            end
            SETUP: begin
                stateNext = WR_LOW;
                timerNext = LOW_LOAD;
            end
            WR_LOW: begin
                if (timer == 24'd0) begin
                    stateNext = WR_HIGH;
                    timerNext = HIGH_LOAD;
                end else begin
                    timerNext = timer - 24'd1;
                end
            end
            WR_HIGH: begin
                if (timer != 24'd0) begin
                    timerNext = timer - 24'd1;
                end else if (runCnt != 14'd0) begin
                    runCntNext = runCnt - 14'd1;
                    stateNext  = SETUP;
                end else begin
                    stateNext = IDLE;
                end
            end
            DELAY: begin
                if (timer == 24'd0) begin
                    stateNext = IDLE;
                end else begin
                    timerNext = timer - 24'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state register, glitch-free.
    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            state     <= IDLE;
            timer     <= 24'd0;
            runCnt    <= 14'd0;
            o_lcdData <= 16'h0000;
            o_lcdDc   <= 1'b0;
            o_lcdWr_n <= 1'b1;
            o_lcdCs_n <= 1'b1;
        end else begin
            state     <= stateNext;
            timer     <= timerNext;
            runCnt    <= runCntNext;
            o_lcdData <= dataNext;
            o_lcdDc   <= dcNext;
            o_lcdWr_n <= (stateNext != WR_LOW);
            o_lcdCs_n <= (stateNext == IDLE);
        end
    end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: FIFO model, bus monitor and per-word timing model.
module tb_lcd_write_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN;
    logic        en;
    logic [31:0] fifoData  = 32'h0;
    logic        fifoEmpty = 1'b1;
    logic        fifoRd;
    logic [15:0] lcdData;
    logic        lcdDc, lcdWr_n, lcdCs_n, busy;

    logic        en2, fe2;
    logic [31:0] fd2;
    logic        rd2;
    logic [15:0] data2;
    logic        dc2, wr2, cs2, busy2;

    int errors = 0;
    int checks = 0;

    lcd_write_sequencer dut (
        .i_clock(clk), .i_nReset(rstN), .i_enable(en),
        .i_fifoData(fifoData), .i_fifoEmpty(fifoEmpty), .o_fifoRead(fifoRd),
        .o_lcdData(lcdData), .o_lcdDc(lcdDc), .o_lcdWr_n(lcdWr_n),
        .o_lcdCs_n(lcdCs_n), .o_busy(busy)
    );

    lcd_write_sequencer #(.WR_LOW_CYCLES(1), .WR_HIGH_CYCLES(3)) dut2 (
        .i_clock(clk), .i_nReset(rstN), .i_enable(en2),
        .i_fifoData(fd2), .i_fifoEmpty(fe2), .o_fifoRead(rd2),
        .o_lcdData(data2), .o_lcdDc(dc2), .o_lcdWr_n(wr2),
        .o_lcdCs_n(cs2), .o_busy(busy2)
    );

    // FIFO contents are pushed by the tests; the monitor alone advances the read pointer.
    logic [31:0] fifoQ[$];
    int          rdPtr = 0;

    int          cyc = 0, lowCnt = 0, busyCnt = 0, stabErr = 0;
    bit          popNow;
    logic        prevWr = 1'b1, prevCs = 1'b1, prevDc = 1'b0, prevRst = 1'b0;
    logic [15:0] prevData = 16'h0;
    int          popLog[$], riseLog[$], lowLog[$];
    logic [16:0] wrLog[$];

    always @(posedge clk) begin
        popNow = fifoRd;
        #1;
        cyc++;
        if (popNow) begin
            popLog.push_back(cyc);
            rdPtr++;
        end
        fifoEmpty = (rdPtr >= fifoQ.size());
        fifoData  = fifoEmpty ? 32'h0 : fifoQ[rdPtr];
        if (rstN && prevRst) begin
            if (!lcdWr_n) lowCnt++;
            if (lcdWr_n && !prevWr) begin
                wrLog.push_back({lcdDc, lcdData});
                riseLog.push_back(cyc);
                lowLog.push_back(lowCnt);
                lowCnt = 0;
            end
            if (!prevCs && (lcdData != prevData || lcdDc != prevDc)) stabErr++;
            if (!lcdWr_n && lcdCs_n) stabErr++;
            if (busy) busyCnt++;
        end else begin
            lowCnt = 0;
        end
        prevWr = lcdWr_n; prevCs = lcdCs_n; prevDc = lcdDc; prevData = lcdData; prevRst = rstN;
    end

    task automatic waitIdle(input int bound, output bit ok);
        ok = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (fifoEmpty && !busy && !fifoRd) ok = 1;
        end
    endtask

    task automatic test_reset;
        int p0, r0;
        bit ok;
        @(negedge clk);
        checks++; if (lcdWr_n !== 1'b1) begin errors++; $display("FAIL rst_wr: got %b want 1", lcdWr_n); end
        checks++; if (lcdCs_n !== 1'b1) begin errors++; $display("FAIL rst_cs: got %b want 1", lcdCs_n); end
        checks++; if (lcdDc !== 1'b0) begin errors++; $display("FAIL rst_dc: got %b want 0", lcdDc); end
        checks++; if (lcdData !== 16'h0) begin errors++; $display("FAIL rst_data: got %h want 0000", lcdData); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (fifoRd !== 1'b0) begin errors++; $display("FAIL rst_rd: got %b want 0", fifoRd); end
        rstN = 1'b1;
        fifoQ.push_back(32'h0005_1234);
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (!lcdWr_n) ok = 1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL rst_run_start: got no strobe want WR low"); end
        #2 rstN = 1'b0;
        #1;
        checks++; if (lcdWr_n !== 1'b1) begin errors++; $display("FAIL rst_async_wr: got %b want 1", lcdWr_n); end
        checks++; if (lcdCs_n !== 1'b1) begin errors++; $display("FAIL rst_async_cs: got %b want 1", lcdCs_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        p0 = popLog.size(); r0 = riseLog.size();
        fifoQ.push_back(32'h4000_002C);
        repeat (3) @(negedge clk);
        checks++; if (fifoRd !== 1'b0) begin errors++; $display("FAIL rst_no_pop: got %b want 0", fifoRd); end
        en = 1'b0;
        @(negedge clk) rstN = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (popLog.size() != p0) begin errors++; $display("FAIL rst_pops: got %0d want %0d", popLog.size(), p0); end
        checks++; if (riseLog.size() != r0) begin errors++; $display("FAIL rst_writes: got %0d want %0d", riseLog.size(), r0); end
        en = 1'b1;
        waitIdle(100, ok);
        checks++; if (!ok || riseLog.size() != r0 + 1) begin errors++; $display("FAIL rst_after: got ok=%0d writes=%0d want 1", ok, riseLog.size() - r0); end
        else begin
            checks++; if (wrLog[r0] !== {1'b0, 16'h002C}) begin errors++; $display("FAIL rst_after_word: got %h want 0002c", wrLog[r0]); end
        end
    endtask

    task automatic test_cmd_data;
        int p0, r0;
        bit ok;
        en = 1'b0;
        fifoQ.push_back(32'h4000_002C);
        fifoQ.push_back(32'h8000_00A5);
        repeat (2) @(negedge clk);
        p0 = popLog.size(); r0 = riseLog.size();
        en = 1'b1;
        waitIdle(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cd_timeout: got busy want idle"); end
        checks++; if (popLog.size() - p0 != 2) begin errors++; $display("FAIL cd_pops: got %0d want 2", popLog.size() - p0); end
        checks++; if (riseLog.size() - r0 != 2) begin errors++; $display("FAIL cd_writes: got %0d want 2", riseLog.size() - r0); end
        if (popLog.size() - p0 == 2 && riseLog.size() - r0 == 2) begin
            checks++; if (wrLog[r0] !== {1'b0, 16'h002C}) begin errors++; $display("FAIL cd_first: got %h want 0002c", wrLog[r0]); end
            checks++; if (wrLog[r0+1] !== {1'b1, 16'h00A5}) begin errors++; $display("FAIL cd_second: got %h want 100a5", wrLog[r0+1]); end
            checks++; if (lowLog[r0] != 2 || lowLog[r0+1] != 2) begin errors++; $display("FAIL cd_low: got %0d,%0d want 2,2", lowLog[r0], lowLog[r0+1]); end
            checks++; if (popLog[p0+1] - popLog[p0] != 6) begin errors++; $display("FAIL cd_pop_gap: got %0d want 6", popLog[p0+1] - popLog[p0]); end
        end
    endtask

    task automatic test_pixel_run;
        int p0, r0, b0;
        bit ok;
        p0 = popLog.size(); r0 = riseLog.size(); b0 = busyCnt;
        fifoQ.push_back(32'h0003_F800);
        waitIdle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL px_timeout: got busy want idle"); end
        checks++; if (popLog.size() - p0 != 1) begin errors++; $display("FAIL px_pops: got %0d want 1", popLog.size() - p0); end
        checks++; if (riseLog.size() - r0 != 4) begin errors++; $display("FAIL px_writes: got %0d want 4", riseLog.size() - r0); end
        for (int i = 0; i < 4 && r0 + i < wrLog.size(); i++) begin
            checks++; if (wrLog[r0+i] !== {1'b1, 16'hF800}) begin errors++; $display("FAIL px_word%0d: got %h want 1f800", i, wrLog[r0+i]); end
        end
        checks++; if (busyCnt - b0 != 20) begin errors++; $display("FAIL px_busy: got %0d want 20", busyCnt - b0); end
    endtask

    task automatic test_delay;
        int p0, r0;
        bit ok;
        en = 1'b0;
        fifoQ.push_back(32'hC000_0010);
        fifoQ.push_back(32'h4000_0001);
        repeat (2) @(negedge clk);
        p0 = popLog.size(); r0 = riseLog.size();
        en = 1'b1;
        waitIdle(200, ok);
        checks++; if (!ok || popLog.size() - p0 != 2 || riseLog.size() - r0 != 1) begin
            errors++; $display("FAIL dly_counts: got pops=%0d writes=%0d want 2,1", popLog.size() - p0, riseLog.size() - r0);
        end else begin
            checks++; if (riseLog[r0] - popLog[p0] != 20) begin errors++; $display("FAIL dly_edge: got %0d want 20", riseLog[r0] - popLog[p0]); end
            checks++; if (popLog[p0+1] - popLog[p0] != 17) begin errors++; $display("FAIL dly_gap: got %0d want 17", popLog[p0+1] - popLog[p0]); end
            checks++; if (lowLog[r0] != 2) begin errors++; $display("FAIL dly_low: got %0d want 2", lowLog[r0]); end
            checks++; if (wrLog[r0] !== {1'b0, 16'h0001}) begin errors++; $display("FAIL dly_word: got %h want 00001", wrLog[r0]); end
        end
        en = 1'b0;
        fifoQ.push_back(32'hC000_0000);
        fifoQ.push_back(32'h8000_0077);
        repeat (2) @(negedge clk);
        p0 = popLog.size(); r0 = riseLog.size();
        en = 1'b1;
        waitIdle(100, ok);
        checks++; if (!ok || popLog.size() - p0 != 2 || riseLog.size() - r0 != 1) begin
            errors++; $display("FAIL dly0_counts: got pops=%0d writes=%0d want 2,1", popLog.size() - p0, riseLog.size() - r0);
        end else begin
            checks++; if (popLog[p0+1] - popLog[p0] != 1) begin errors++; $display("FAIL dly0_gap: got %0d want 1", popLog[p0+1] - popLog[p0]); end
            checks++; if (wrLog[r0] !== {1'b1, 16'h0077}) begin errors++; $display("FAIL dly0_word: got %h want 10077", wrLog[r0]); end
        end
    endtask

    task automatic test_enable_drop;
        int p0, r0;
        bit ok;
        p0 = popLog.size(); r0 = riseLog.size();
        fifoQ.push_back(32'h0002_0055);
        fifoQ.push_back(32'h4000_0099);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (riseLog.size() > r0) ok = 1;
        end
        en = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (riseLog.size() - r0 != 3) begin errors++; $display("FAIL en_writes: got %0d want 3", riseLog.size() - r0); end
        checks++; if (popLog.size() - p0 != 1) begin errors++; $display("FAIL en_pops: got %0d want 1", popLog.size() - p0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_busy: got %b want 0", busy); end
        for (int i = 0; i < 3 && r0 + i < wrLog.size(); i++) begin
            checks++; if (wrLog[r0+i] !== {1'b1, 16'h0055}) begin errors++; $display("FAIL en_word%0d: got %h want 10055", i, wrLog[r0+i]); end
        end
        en = 1'b1;
        waitIdle(100, ok);
        checks++; if (!ok || riseLog.size() - r0 != 4) begin errors++; $display("FAIL en_resume: got writes=%0d want 4", riseLog.size() - r0); end
        else begin
            checks++; if (wrLog[r0+3] !== {1'b0, 16'h0099}) begin errors++; $display("FAIL en_resume_word: got %h want 00099", wrLog[r0+3]); end
        end
    endtask

    task automatic test_empty;
        int rdSeen;
        rdSeen = 0;
        en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fifoRd) rdSeen++;
        end
        checks++; if (rdSeen != 0) begin errors++; $display("FAIL empty_rd: got %0d pops want 0", rdSeen); end
    endtask

    task automatic test_random;
        logic [16:0] expW[$];
        int          dur[$];
        int          sumDur, p0, r0, b0, t, n;
        logic [31:0] r, w;
        bit          ok;
        en = 1'b0;
        sumDur = 0;
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            t = $urandom_range(0, 3);
            case (t)
                0: begin
                    n = $urandom_range(0, 6);
                    w = {2'b00, 14'(n), r[15:0]};
                    for (int k = 0; k <= n; k++) expW.push_back({1'b1, r[15:0]});
                    dur.push_back((n + 1) * 5);
                end
                1, 2: begin
                    w = {2'(t), r[29:0]};
                    expW.push_back({t == 2, 8'h00, r[7:0]});
                    dur.push_back(5);
                end
                default: begin
                    n = $urandom_range(0, 25);
                    w = {2'b11, r[29:24], 24'(n)};
                    dur.push_back(n);
                end
            endcase
            fifoQ.push_back(w);
            sumDur += dur[i];
        end
        repeat (2) @(negedge clk);
        p0 = popLog.size(); r0 = riseLog.size(); b0 = busyCnt;
        en = 1'b1;
        waitIdle(6000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rnd_timeout: got busy want idle"); end
        checks++; if (popLog.size() - p0 != 40) begin errors++; $display("FAIL rnd_pops: got %0d want 40", popLog.size() - p0); end
        checks++; if (riseLog.size() - r0 != expW.size()) begin errors++; $display("FAIL rnd_writes: got %0d want %0d", riseLog.size() - r0, expW.size()); end
        for (int i = 0; i < expW.size() && r0 + i < wrLog.size(); i++) begin
            checks++; if (wrLog[r0+i] !== expW[i]) begin errors++; $display("FAIL rnd_word%0d: got %h want %h", i, wrLog[r0+i], expW[i]); end
            checks++; if (lowLog[r0+i] != 2) begin errors++; $display("FAIL rnd_low%0d: got %0d want 2", i, lowLog[r0+i]); end
        end
        for (int i = 0; i < 39 && p0 + i + 1 < popLog.size(); i++) begin
            checks++; if (popLog[p0+i+1] - popLog[p0+i] != dur[i] + 1) begin
                errors++; $display("FAIL rnd_gap%0d: got %0d want %0d", i, popLog[p0+i+1] - popLog[p0+i], dur[i] + 1);
            end
        end
        checks++; if (busyCnt - b0 != sumDur) begin errors++; $display("FAIL rnd_busy: got %0d want %0d", busyCnt - b0, sumDur); end
    endtask

    task automatic test_timing_params;
        int lowN, holdN;
        bit seenLow, done, gotPop;
        lowN = 0; holdN = 0; seenLow = 0; done = 0; gotPop = 0;
        @(negedge clk);
        fd2 = 32'h8000_005A; fe2 = 1'b0; en2 = 1'b1;
        for (int i = 0; i < 10 && !gotPop; i++) begin
            @(negedge clk);
            if (rd2) gotPop = 1;
        end
        @(negedge clk);
        fe2 = 1'b1; en2 = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            if (!wr2) begin
                lowN++; seenLow = 1;
            end else if (seenLow && !cs2) begin
                if (data2 == 16'h005A && dc2) holdN++;
            end else if (seenLow && cs2) begin
                done = 1;
            end
            if (!done) @(negedge clk);
        end
        checks++; if (!gotPop || !done) begin errors++; $display("FAIL tp_done: got pop=%0d done=%0d want 1,1", gotPop, done); end
        checks++; if (lowN != 1) begin errors++; $display("FAIL tp_low: got %0d want 1", lowN); end
        checks++; if (holdN != 3) begin errors++; $display("FAIL tp_hold: got %0d want 3", holdN); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL tp_busy: got %b want 0", busy2); end
    endtask

    initial begin
        rstN = 1'b1; en = 1'b0; en2 = 1'b0; fd2 = 32'h0; fe2 = 1'b1;
        #1 rstN = 1'b0;
        en = 1'b1;
        test_reset;
        test_cmd_data;
        test_pixel_run;
        test_delay;
        test_enable_drop;
        test_empty;
        test_random;
        test_timing_params;
        checks++; if (stabErr != 0) begin errors++; $display("FAIL bus_stability: got %0d violations want 0", stabErr); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
